// File: rtl/dds_key_tuner.sv
// dds_key_tuner: key-edited frequency setpoint driving a DDS phase accumulator, waveform ROM address and DAC select.
// Optional PHASE_DITHER_EN adds LFSR dither to the truncated phase bits ahead of rom_addr and the saw/triangle fields.
module dds_key_tuner #(
    parameter int PHASE_W   = 32,
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 8,
    parameter int FREQ_W    = 20,
    parameter int DIGITS    = 6,
    parameter int F_MIN     = 50,
    parameter int F_MAX     = 25000,
    parameter int F_INIT    = 50,
    parameter int TW_PER_HZ = 86
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         key_in,
    input  logic               run,
    input  logic               phase_clr,
    input  logic [DATA_W-1:0]  rom_q,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic [DATA_W-1:0]  dac_value,
    output logic [FREQ_W-1:0]  freq_hz,
    output logic [PHASE_W-1:0] tuning_word,
    output logic [DIGITS-1:0]  digit_sel,
    output logic [1:0]         mode
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [PHASE_W-1:0] TW = PHASE_W'(TW_PER_HZ);

    logic [4:0]         key_q, rise;
    logic               armed;
    logic [IW-1:0]      idx, idx_nxt;
    logic [31:0]        step;
    logic               up_ok, dn_ok, do_inc, do_dec;
    logic [PHASE_W-1:0] phase;
    logic [ADDR_W-1:0]  pt;
    logic [DATA_W-1:0]  saw, tri_v, gen, gen_q;
    logic [1:0]         mode_q;

    // armed stays low for the first cycle so keys held through reset never fire
    assign rise      = armed ? key_in & ~key_q : 5'b0;
    assign digit_sel = DIGITS'(1) << idx;

    always_comb begin
        step = 32'd1;
        for (int i = 1; i < DIGITS; i++)
            if (i <= int'(idx)) step = step * 32'd10;
    end

    assign up_ok  = 33'(freq_hz) + 33'(step) <= 33'(F_MAX);
    assign dn_ok  = 33'(freq_hz) >= 33'(step) + 33'(F_MIN);
    assign do_inc = rise[0] & ~rise[1] & up_ok;
    assign do_dec = rise[1] & ~rise[0] & dn_ok;

    assign idx_nxt = (rise[2] & ~rise[3]) ? (idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1)) :
                     (rise[3] & ~rise[2]) ? (idx == '0 ? IW'(DIGITS - 1) : idx - IW'(1)) : idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q       <= '0;
            armed       <= 1'b0;
            freq_hz     <= FREQ_W'(F_INIT);
            idx         <= '0;
            mode        <= '0;
            tuning_word <= PHASE_W'(F_INIT * TW_PER_HZ);
        end else begin
            key_q       <= key_in;
            armed       <= 1'b1;
            freq_hz     <= do_inc ? freq_hz + FREQ_W'(step) : do_dec ? freq_hz - FREQ_W'(step) : freq_hz;
            idx         <= idx_nxt;
            mode        <= mode + 2'(rise[4]);
            tuning_word <= PHASE_W'(freq_hz) * TW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase <= '0;
        else if (phase_clr) phase <= '0;
        else if (run) phase <= phase + tuning_word;
    end

`ifdef PHASE_DITHER_EN
    localparam int DW = (PHASE_W - ADDR_W) < 16 ? (PHASE_W - ADDR_W) : 16;
    logic [15:0] lfsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 16'hACE1;
        else if (run) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign pt = ADDR_W'((phase + PHASE_W'(lfsr[DW-1:0])) >> (PHASE_W - ADDR_W));
`else
    assign pt = phase[PHASE_W-1 -: ADDR_W];
`endif

    assign saw   = pt[ADDR_W-1 -: DATA_W];
    assign tri_v = pt[ADDR_W-2 -: DATA_W] ^ {DATA_W{pt[ADDR_W-1]}};
    assign gen   = mode == 2'd1 ? {DATA_W{phase[PHASE_W-1]}} : mode == 2'd2 ? saw : tri_v;

    // generated waveforms ride a register alongside the ROM read so all modes share one latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr  <= '0;
            gen_q     <= '0;
            mode_q    <= '0;
            dac_value <= '0;
        end else begin
            rom_addr  <= pt;
            gen_q     <= gen;
            mode_q    <= mode;
            dac_value <= mode_q == 2'd0 ? rom_q : gen_q;
        end
    end
endmodule

// File: tb/tb_dds_key_tuner.sv
// tb_dds_key_tuner: scoreboard bench for dds_key_tuner; ROM is modelled as rom_addr[10:3] ^ 8'hA5.
module tb_dds_key_tuner;
    logic        clk = 1'b0, rst = 1'b1, run = 1'b0, phase_clr = 1'b0;
    logic [4:0]  key_in = 5'h0;
    logic [7:0]  rom_q, dac_value;
    logic [10:0] rom_addr;
    logic [19:0] freq_hz;
    logic [31:0] tuning_word;
    logic [5:0]  digit_sel;
    logic [1:0]  mode;

    int total = 0, bad = 0;
    int exp_freq = 50, exp_idx = 0, exp_mode = 0;
    int m_f1 = 50;
    logic [31:0] m_phase = 0, m_tw = 32'd4300;
    logic [7:0]  dq[$];
    logic [10:0] aq[$];

    dds_key_tuner dut (
        .clk(clk), .rst(rst), .key_in(key_in), .run(run), .phase_clr(phase_clr),
        .rom_q(rom_q), .rom_addr(rom_addr), .dac_value(dac_value), .freq_hz(freq_hz),
        .tuning_word(tuning_word), .digit_sel(digit_sel), .mode(mode)
    );

    assign rom_q = rom_addr[10:3] ^ 8'hA5;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_dac(input int md, input logic [31:0] ph);
        case (md)
            0: return ph[31:24] ^ 8'hA5;
            1: return {8{ph[31]}};
            2: return ph[31:24];
            default: return ph[31] ? ~ph[30:23] : ph[30:23];
        endcase
    endfunction

    // model: dac after edge k reflects mode/phase after edge k-2, rom_addr reflects phase after edge k-1
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_phase = 0;
            m_tw = 32'd4300;
            m_f1 = 50;
            dq = '{8'hA5, 8'hA5};
            aq = '{11'd0};
        end else begin
            if (phase_clr) m_phase = 0;
            else if (run) m_phase = m_phase + m_tw;
            m_tw = 32'(m_f1 * 86);
            m_f1 = exp_freq;
            dq.push_back(exp_dac(exp_mode, m_phase));
            if (dq.size() > 3) dq.delete(0);
            aq.push_back(m_phase[31:21]);
            if (aq.size() > 2) aq.delete(0);
        end
    end

    task automatic press(input logic [4:0] m);
        int step;
        @(negedge clk);
        step = 10 ** exp_idx;
        if (m[0] && !m[1] && exp_freq + step <= 25000) exp_freq += step;
        if (m[1] && !m[0] && exp_freq - step >= 50) exp_freq -= step;
        if (m[2] && !m[3]) exp_idx = (exp_idx + 1) % 6;
        if (m[3] && !m[2]) exp_idx = (exp_idx + 5) % 6;
        if (m[4]) exp_mode = (exp_mode + 1) % 4;
        key_in = m;
        @(negedge clk);
        key_in = 5'h0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        key_in = 5'b10101;
        repeat (3) @(negedge clk);
        total++; if (freq_hz !== 20'd50) begin bad++; $display("FAIL rst_freq: got %0d want 50", freq_hz); end
        total++; if (tuning_word !== 32'd4300) begin bad++; $display("FAIL rst_tw: got %0d want 4300", tuning_word); end
        total++; if (digit_sel !== 6'b000001) begin bad++; $display("FAIL rst_digit: got %b want 000001", digit_sel); end
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL rst_mode: got %0d want 0", mode); end
        total++; if (dac_value !== 8'h00) begin bad++; $display("FAIL rst_dac: got %h want 00", dac_value); end
        total++; if (rom_addr !== 11'd0) begin bad++; $display("FAIL rst_addr: got %h want 000", rom_addr); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (freq_hz !== 20'd50) begin bad++; $display("FAIL held_freq: got %0d want 50", freq_hz); end
        total++; if (digit_sel !== 6'b000001) begin bad++; $display("FAIL held_digit: got %b want 000001", digit_sel); end
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL held_mode: got %0d want 0", mode); end
        key_in = 5'h0;
        @(negedge clk);
    endtask

    task automatic test_inc_hold;
        repeat (2) press(5'h04);
        total++; if (digit_sel !== 6'b000100) begin bad++; $display("FAIL left2: got %b want 000100", digit_sel); end
        @(negedge clk);
        key_in = 5'h01;
        exp_freq = 150;
        @(negedge clk);
        total++; if (freq_hz !== 20'd150) begin bad++; $display("FAIL inc_freq: got %0d want 150", freq_hz); end
        total++; if (tuning_word !== 32'd4300) begin bad++; $display("FAIL tw_lag: got %0d want 4300", tuning_word); end
        @(negedge clk);
        total++; if (tuning_word !== 32'd12900) begin bad++; $display("FAIL tw_150: got %0d want 12900", tuning_word); end
        repeat (98) @(negedge clk);
        total++; if (freq_hz !== 20'd150) begin bad++; $display("FAIL hold_once: got %0d want 150", freq_hz); end
        key_in = 5'h0;
    endtask

    task automatic test_low_limits;
        press(5'h03);
        total++; if (freq_hz !== 20'd150) begin bad++; $display("FAIL inc_dec_same: got %0d want 150", freq_hz); end
        press(5'h02);
        total++; if (freq_hz !== 20'd50) begin bad++; $display("FAIL dec_to_min: got %0d want 50", freq_hz); end
        repeat (2) press(5'h08);
        press(5'h02);
        total++; if (freq_hz !== 20'd50) begin bad++; $display("FAIL dec_below_min: got %0d want 50", freq_hz); end
        total++; if (digit_sel !== 6'b000001) begin bad++; $display("FAIL right2: got %b want 000001", digit_sel); end
    endtask

    task automatic test_saw_50;
        logic [7:0] e;
        logic [10:0] a;
        repeat (2) press(5'h10);
        total++; if (mode !== 2'd2) begin bad++; $display("FAIL mode_saw: got %0d want 2", mode); end
        @(negedge clk);
        phase_clr = 1'b1;
        run = 1'b1;
        @(negedge clk);
        phase_clr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dq.size() == 3) begin
                e = dq.pop_front();
                total++; if (dac_value !== e) begin bad++; $display("FAIL saw50_dac[%0d]: got %h want %h", i, dac_value, e); end
            end
            if (aq.size() == 2) begin
                a = aq.pop_front();
                total++; if (rom_addr !== a) begin bad++; $display("FAIL saw50_addr[%0d]: got %h want %h", i, rom_addr, a); end
            end
        end
        run = 1'b0;
    endtask

    task automatic test_high;
        repeat (4) press(5'h04);
        repeat (2) press(5'h01);
        press(5'h08);
        repeat (4) press(5'h01);
        press(5'h08);
        repeat (9) press(5'h01);
        total++; if (freq_hz !== 20'd24950) begin bad++; $display("FAIL ramp: got %0d want 24950", freq_hz); end
        press(5'h01);
        total++; if (freq_hz !== 20'd24950) begin bad++; $display("FAIL inc_over_max: got %0d want 24950", freq_hz); end
        press(5'h08);
        repeat (5) press(5'h01);
        total++; if (freq_hz !== 20'd25000) begin bad++; $display("FAIL inc_to_max: got %0d want 25000", freq_hz); end
        total++; if (freq_hz !== 20'(exp_freq)) begin bad++; $display("FAIL freq_model: got %0d want %0d", freq_hz, exp_freq); end
        @(negedge clk);
        total++; if (tuning_word !== 32'd2150000) begin bad++; $display("FAIL tw_max: got %0d want 2150000", tuning_word); end
    endtask

    task automatic test_digit_wrap;
        repeat (4) press(5'h04);
        total++; if (digit_sel !== 6'b100000) begin bad++; $display("FAIL digit_top: got %b want 100000", digit_sel); end
        press(5'h04);
        total++; if (digit_sel !== 6'b000001) begin bad++; $display("FAIL left_wrap: got %b want 000001", digit_sel); end
        press(5'h08);
        total++; if (digit_sel !== 6'b100000) begin bad++; $display("FAIL right_wrap: got %b want 100000", digit_sel); end
        press(5'h0C);
        total++; if (digit_sel !== 6'b100000) begin bad++; $display("FAIL left_right_same: got %b want 100000", digit_sel); end
    endtask

    task automatic test_wrap;
        logic [7:0] e;
        logic [10:0] a;
        logic [31:0] last;
        bit wrapped;
        int after;
        wrapped = 0;
        after = 0;
        last = m_phase;
        run = 1'b1;
        for (int i = 0; i < 3000 && after < 8; i++) begin
            @(negedge clk);
            if (m_phase < last) wrapped = 1;
            last = m_phase;
            if (wrapped) after++;
            if (dq.size() == 3) begin
                e = dq.pop_front();
                total++; if (dac_value !== e) begin bad++; $display("FAIL wrap_dac[%0d]: got %h want %h", i, dac_value, e); end
            end
            if (aq.size() == 2) begin
                a = aq.pop_front();
                total++; if (rom_addr !== a) begin bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, rom_addr, a); end
            end
        end
        total++; if (!wrapped) begin bad++; $display("FAIL wrap_timeout: got no wrap want wrap within 3000 cycles"); end
        phase_clr = 1'b1;
        @(negedge clk);
        phase_clr = 1'b0;
        @(negedge clk);
        total++; if (rom_addr !== 11'd0) begin bad++; $display("FAIL clr_addr: got %h want 000", rom_addr); end
    endtask

    task automatic test_modes;
        logic [10:0] hold_a;
        bit hit;
        hit = 0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            if (m_phase >= 32'hC000_0000 && m_phase <= 32'hC07F_FFFF) begin
                run = 1'b0;
                hit = 1;
            end
        end
        total++; if (!hit) begin bad++; $display("FAIL window_timeout: got no hit want phase in C0000000..C07FFFFF"); end
        press(5'h10);
        repeat (3) @(negedge clk);
        total++; if (dac_value !== 8'h7F) begin bad++; $display("FAIL tri_c0: got %h want 7f", dac_value); end
        repeat (2) press(5'h10);
        repeat (3) @(negedge clk);
        total++; if (dac_value !== 8'hFF) begin bad++; $display("FAIL sq_c0: got %h want ff", dac_value); end
        hold_a = m_phase[31:21];
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            total++; if (rom_addr !== hold_a) begin bad++; $display("FAIL hold_addr[%0d]: got %h want %h", i, rom_addr, hold_a); end
        end
    endtask

    task automatic test_rom;
        logic [7:0] e;
        repeat (3) press(5'h10);
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL mode_rom: got %0d want 0", mode); end
        run = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dq.size() == 3) begin
                e = dq.pop_front();
                total++; if (dac_value !== e) begin bad++; $display("FAIL rom_dac[%0d]: got %h want %h", i, dac_value, e); end
            end
        end
    endtask

    task automatic test_async_reset;
        logic [7:0] e;
        press(5'h10);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (freq_hz !== 20'd50) begin bad++; $display("FAIL arst_freq: got %0d want 50", freq_hz); end
        total++; if (tuning_word !== 32'd4300) begin bad++; $display("FAIL arst_tw: got %0d want 4300", tuning_word); end
        total++; if (digit_sel !== 6'b000001) begin bad++; $display("FAIL arst_digit: got %b want 000001", digit_sel); end
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL arst_mode: got %0d want 0", mode); end
        total++; if (dac_value !== 8'h00) begin bad++; $display("FAIL arst_dac: got %h want 00", dac_value); end
        total++; if (rom_addr !== 11'd0) begin bad++; $display("FAIL arst_addr: got %h want 000", rom_addr); end
        exp_freq = 50;
        exp_idx = 0;
        exp_mode = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dq.size() == 3) begin
                e = dq.pop_front();
                total++; if (dac_value !== e) begin bad++; $display("FAIL arst_run_dac[%0d]: got %h want %h", i, dac_value, e); end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_inc_hold();
        test_low_limits();
        test_saw_50();
        test_high();
        test_digit_wrap();
        test_wrap();
        test_modes();
        test_rom();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
